nibble_serial_subtractor: RTL and testbench



---
 rtl/nibble_serial_subtractor_pkg.sv | 19 +
 rtl/nibble_borrow_select_sub.sv | 24 ++
 rtl/nibble_serial_subtractor.sv | 148 ++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared constants, FSM state type and index sizing for the nibble-serial subtractor.
package nsub_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Nibble index width for an n-bit operand; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned nibbles;
    nibbles = n / NIBBLE_W;
    return (nibbles <= 1) ? 1 : unsigned'($clog2(nibbles));
  endfunction

endpackage

// File: rtl/nibble_borrow_select_sub.sv
// One 4-bit subtract slice: both borrow-in outcomes are formed up front and bin picks one.
module nibble_borrow_select_sub
  import nsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] d,
  output logic                bout
);

  localparam int unsigned SUM_W = NIBBLE_W + 1;

  logic [SUM_W-1:0] sum_b0;
  logic [SUM_W-1:0] sum_b1;

  // a - b - bin as a + ~b + !bin; borrow-out is the inverted carry.
  assign sum_b0 = {1'b0, a} + {1'b0, ~b} + SUM_W'(1);
  assign sum_b1 = {1'b0, a} + {1'b0, ~b};

  assign d    = bin ? sum_b1[NIBBLE_W-1:0] : sum_b0[NIBBLE_W-1:0];
  assign bout = bin ? ~sum_b1[NIBBLE_W]    : ~sum_b0[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// N-bit a - b - bin computed one nibble per clock behind valid/ready handshakes.
// Define NSUB_OVF_EN to add the registered signed-overflow output ovf.
module nibble_serial_subtractor
  import nsub_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout
`ifdef NSUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned NIB   = N / NIBBLE_W;
  localparam int unsigned IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [N-1:0]     diff_d;
  logic             bout_d;
  logic             in_ready_d;
  logic             out_valid_d;
`ifdef NSUB_OVF_EN
  logic             ovf_d;
`endif

  logic [IDX_W+1:0]    bit_base;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_d;
  logic                nib_bout;

  assign bit_base = {idx_q, 2'b00};
  assign nib_a    = a_q[bit_base +: NIBBLE_W];
  assign nib_b    = b_q[bit_base +: NIBBLE_W];

  nibble_borrow_select_sub u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .bin  (borrow_q),
    .d    (nib_d),
    .bout (nib_bout)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    borrow_d    = borrow_q;
    diff_d      = diff;
    bout_d      = bout;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
`ifdef NSUB_OVF_EN
    ovf_d       = ovf;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d        = a;
          b_d        = b;
          borrow_d   = bin;
          idx_d      = '0;
          diff_d     = '0;
          bout_d     = 1'b0;
`ifdef NSUB_OVF_EN
          ovf_d      = 1'b0;
`endif
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        diff_d[bit_base +: NIBBLE_W] = nib_d;
        borrow_d = nib_bout;
        if (idx_q == LAST_IDX) begin
          bout_d      = nib_bout;
`ifdef NSUB_OVF_EN
          // Overflow only when operand signs differ and the result sign leaves a's.
          ovf_d       = (a_q[N-1] != b_q[N-1]) && (nib_d[NIBBLE_W-1] != a_q[N-1]);
`endif
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      borrow_q  <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef NSUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      borrow_q  <= borrow_d;
      diff      <= diff_d;
      bout      <= bout_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
`ifdef NSUB_OVF_EN
      ovf       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed vector table plus stall, abort and streaming sequences for N=64 and N=8 instances.
module tb_nibble_serial_subtractor;

  logic clk;
  logic rst_n;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, bin64, bout64;
  logic [63:0] a64, b64, diff64;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, bin8, bout8;
  logic [7:0]  a8, b8, diff8;
`ifdef NSUB_OVF_EN
  logic        ovf64, ovf8;
`endif

  int  n_vec = 0;
  int  n_err = 0;
  time t_acc64 = 0;

  nibble_serial_subtractor #(.N(64)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .a(a64), .b(b64), .bin(bin64), .out_valid(out_valid64), .out_ready(out_ready64),
    .diff(diff64), .bout(bout64)
`ifdef NSUB_OVF_EN
    , .ovf(ovf64)
`endif
  );

  nibble_serial_subtractor #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8)
`ifdef NSUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Drive one N=64 operation through accept, compute and consume.
  task automatic do64(input logic [63:0] a_v, input logic [63:0] b_v, input logic bin_v,
                      input bit rnd, output logic [63:0] d, output logic bo,
                      output logic ov, output int lat);
    int  g;
    bit  hs;
    @(negedge clk);
    a64 = a_v; b64 = b_v; bin64 = bin_v; in_valid64 = 1'b1;
    g = 0;
    while (!in_ready64 && g < 100) begin @(negedge clk); g++; end
    @(posedge clk);
    t_acc64 = $time;
    #1 in_valid64 = 1'b0;
    lat = 0;
    do begin
      if (rnd) out_ready64 = 1'($urandom_range(0, 1));
      @(posedge clk); lat++; #1;
    end while (!out_valid64 && lat < 200);
    d  = diff64;
    bo = bout64;
`ifdef NSUB_OVF_EN
    ov = ovf64;
`else
    ov = 1'b0;
`endif
    hs = 1'b0; g = 0;
    while (!hs && g < 100) begin
      out_ready64 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = out_ready64;
      if (!hs) chk("hold64_diff", diff64, d);
      @(posedge clk); #1; g++;
    end
    out_ready64 = 1'b1;
    chk("rel64_out_valid", 64'(out_valid64), 64'd0);
    chk("rel64_in_ready", 64'(in_ready64), 64'd1);
  endtask

  task automatic do8(input logic [7:0] a_v, input logic [7:0] b_v, input logic bin_v,
                     output logic [7:0] d, output logic bo, output int lat);
    int g;
    bit hs;
    @(negedge clk);
    a8 = a_v; b8 = b_v; bin8 = bin_v; in_valid8 = 1'b1;
    g = 0;
    while (!in_ready8 && g < 100) begin @(negedge clk); g++; end
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    lat = 0;
    do begin
      out_ready8 = 1'($urandom_range(0, 1));
      @(posedge clk); lat++; #1;
    end while (!out_valid8 && lat < 200);
    d = diff8; bo = bout8;
    hs = 1'b0; g = 0;
    while (!hs && g < 100) begin
      out_ready8 = 1'($urandom_range(0, 1));
      hs = out_ready8;
      if (!hs) chk("hold8_diff", 64'(diff8), 64'(d));
      @(posedge clk); #1; g++;
    end
    out_ready8 = 1'b1;
    chk("rel8_out_valid", 64'(out_valid8), 64'd0);
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [63:0] d, ea, eb, ed, prev;
    logic [7:0]  d8, x8, y8;
    logic [8:0]  m8;
    logic [64:0] m64;
    logic        bo, ov, xb;
    int          lat;

    tbl[0] = '{64'd10, 64'd3, 1'b0, 64'd7, 1'b0, 1'b0};
    tbl[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    tbl[2] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               64'h8000_0000_0000_0000, 1'b1, 1'b1};
    tbl[4] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0};
    tbl[5] = '{64'h100, 64'h1, 1'b0, 64'hFF, 1'b0, 1'b0};
    tbl[6] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    tbl[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
               64'h0246_8ACF_1357_9BCE, 1'b0, 1'b0};
    tbl[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    tbl[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid64 = 1'b0; a64 = '0; b64 = '0; bin64 = 1'b0; out_ready64 = 1'b1;
    in_valid8  = 1'b0; a8  = '0; b8  = '0; bin8  = 1'b0; out_ready8  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready64), 64'd1);
    chk("rst_out_valid", 64'(out_valid64), 64'd0);
    chk("rst_diff", diff64, 64'd0);
    chk("rst_bout", 64'(bout64), 64'd0);
`ifdef NSUB_OVF_EN
    chk("rst_ovf", 64'(ovf64), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      do64(tbl[i].a, tbl[i].b, tbl[i].bin, 1'b0, d, bo, ov, lat);
      chk($sformatf("vec%0d_diff", i), d, tbl[i].d);
      chk($sformatf("vec%0d_bout", i), 64'(bo), 64'(tbl[i].bo));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd16);
`ifdef NSUB_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 64'(ov), 64'(tbl[i].ov));
`endif
    end

    // Result held in DONE with in_valid pulses that must be ignored.
    @(negedge clk);
    out_ready64 = 1'b0;
    a64 = 64'h1234_5678_9ABC_DEF0; b64 = 64'h0FED_CBA9_8765_4321; bin64 = 1'b1;
    in_valid64 = 1'b1;
    @(posedge clk);
    #1 in_valid64 = 1'b0;
    lat = 0;
    while (!out_valid64 && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("stall_valid", 64'(out_valid64), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid64 = 1'(i % 2);
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; bin64 = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("stall_diff", diff64, 64'h0246_8ACF_1357_9BCE);
      chk("stall_bout", 64'(bout64), 64'd0);
      chk("stall_in_ready", 64'(in_ready64), 64'd0);
      chk("stall_out_valid", 64'(out_valid64), 64'd1);
    end
    @(negedge clk);
    in_valid64 = 1'b0;
    out_ready64 = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 64'(in_ready64), 64'd1);
    chk("release_out_valid", 64'(out_valid64), 64'd0);

    // Abort mid-RUN via asynchronous reset.
    @(negedge clk);
    a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'd0; bin64 = 1'b0; in_valid64 = 1'b1;
    @(posedge clk);
    #1 in_valid64 = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid64), 64'd0);
    chk("abort_in_ready", 64'(in_ready64), 64'd1);
    chk("abort_diff", diff64, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_result", 64'(out_valid64), 64'd0);
    do64(64'h100, 64'h1, 1'b0, 1'b0, d, bo, ov, lat);
    chk("post_abort_diff", d, 64'hFF);
    chk("post_abort_bout", 64'(bo), 64'd0);

    // N=64 back-to-back with out_ready held high, then with random out_ready.
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      ea = {$urandom, $urandom};
      eb = (i % 3 == 0) ? ea : {$urandom, $urandom};
      xb = 1'($urandom_range(0, 1));
      do64(ea, eb, xb, i >= 8, d, bo, ov, lat);
      m64 = {1'b0, ea} - {1'b0, eb} - 65'(xb);
      ed  = m64[63:0];
      chk("s64_diff", d, ed);
      chk("s64_bout", 64'(bo), 64'(m64[64]));
      chk("s64_latency", 64'(lat), 64'd16);
`ifdef NSUB_OVF_EN
      chk("s64_ovf", 64'(ov), 64'((ea[63] != eb[63]) && (ed[63] != ea[63])));
`endif
      if (i > 0 && i < 8) chk("s64_throughput", 64'((t_acc64 - prev) / 10), 64'd18);
      prev = 64'(t_acc64);
    end

    // N=8 stream with random out_ready, starting at the borrow-through boundary.
    for (int i = 0; i < 30; i++) begin
      x8 = (i == 0) ? 8'd0 : 8'($urandom);
      y8 = (i == 0) ? 8'd0 : 8'($urandom);
      xb = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      do8(x8, y8, xb, d8, bo, lat);
      m8 = {1'b0, x8} - {1'b0, y8} - 9'(xb);
      chk("s8_diff", 64'(d8), 64'(m8[7:0]));
      chk("s8_bout", 64'(bo), 64'(m8[8]));
      chk("s8_latency", 64'(lat), 64'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
